// File: rtl/scratch_stack_pkg.sv
// Shared constants for the scratch stack controller: op codes, FSM encodings, default sizes.
package scratch_stack_pkg;

    localparam int SCRATCH_ADDR_W_DEF = 8;
    localparam int SCRATCH_DATA_W_DEF = 32;

    typedef logic [1:0] op_code_t;

    localparam op_code_t OP_NOP     = 2'b00;
    localparam op_code_t OP_PUSH    = 2'b01;
    localparam op_code_t OP_POP     = 2'b10;
    localparam op_code_t OP_REPLACE = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_CAP  = 2'd3;

endpackage

// File: rtl/scratch_stack_if.sv
// Command port of the scratch stack: valid/ready handshake carrying an op code and operand.
interface scratch_stack_if
    import scratch_stack_pkg::*;
#(
    parameter int DATA_W = SCRATCH_DATA_W_DEF
);
    logic              op_valid;
    logic              op_ready;
    op_code_t          op_code;
    logic [DATA_W-1:0] op_data;

    modport master (output op_valid, output op_code, output op_data, input op_ready);
    modport slave  (input op_valid, input op_code, input op_data, output op_ready);
endinterface

// File: rtl/scratch_stack_ram.sv
// Single-port block RAM with registered read data; read-before-write on a shared address.
module scratch_stack_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset on the array or the output register so the tools map this onto an EBR.
    always_ff @(posedge CLK) begin
        if (wen) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/scratch_stack_ctrl.sv
// Scratch stack sequencer: TOS/NOS in registers, deeper words spilled to block RAM.
// Define SCRATCH_STACK_GUARD_EN to reject overflow/underflow and raise the sticky err flag.
module scratch_stack_ctrl
    import scratch_stack_pkg::*;
#(
    parameter int ADDR_W = SCRATCH_ADDR_W_DEF,
    parameter int DATA_W = SCRATCH_DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              resetn,
    scratch_stack_if.slave    op_if,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [ADDR_W:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              err
);

    localparam logic [ADDR_W:0] SP_ONE   = 1;
    localparam logic [ADDR_W:0] SP_DEPTH = 1 << ADDR_W;

    logic [1:0]        state_reg,  state_next;
    logic [DATA_W-1:0] tos_reg,    tos_next;
    logic [DATA_W-1:0] nos_reg,    nos_next;
    logic [ADDR_W:0]   sp_reg,     sp_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic [DATA_W-1:0] wdata_reg,  wdata_next;
    logic              err_reg,    err_next;

    logic [ADDR_W:0]   sp_dec;
    logic [DATA_W-1:0] rdata;
    logic              ram_wen;
    logic              push_blocked;
    logic              pop_blocked;

    assign sp_dec = sp_reg - SP_ONE;
    assign full   = (sp_reg == SP_DEPTH);
    assign empty  = (sp_reg == '0);

`ifdef SCRATCH_STACK_GUARD_EN
    assign push_blocked = full;
    assign pop_blocked  = empty;
`else
    // Unguarded build: sp and the RAM address simply wrap, and err stays low.
    assign push_blocked = 1'b0;
    assign pop_blocked  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        tos_next   = tos_reg;
        nos_next   = nos_reg;
        sp_next    = sp_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (op_if.op_valid) begin
                    case (op_if.op_code)
                        OP_PUSH: begin
                            if (push_blocked) begin
                                err_next = 1'b1;
                            end else begin
                                tos_next   = op_if.op_data;
                                nos_next   = tos_reg;
                                wdata_next = nos_reg;
                                addr_next  = sp_reg[ADDR_W-1:0];
                                sp_next    = sp_reg + SP_ONE;
                                state_next = ST_WRITE;
                            end
                        end
                        OP_POP: begin
                            if (pop_blocked) begin
                                err_next = 1'b1;
                            end else begin
                                tos_next   = nos_reg;
                                addr_next  = sp_dec[ADDR_W-1:0];
                                sp_next    = sp_dec;
                                state_next = ST_RD_WAIT;
                            end
                        end
                        OP_REPLACE: tos_next = op_if.op_data;
                        default: ;
                    endcase
                end
            end
            ST_WRITE:   state_next = ST_IDLE;
            ST_RD_WAIT: state_next = ST_RD_CAP;
            ST_RD_CAP: begin
                // RAM output now holds the word addressed on the POP accept edge.
                nos_next   = rdata;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            tos_reg   <= '0;
            nos_reg   <= '0;
            sp_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tos_reg   <= tos_next;
            nos_reg   <= nos_next;
            sp_reg    <= sp_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
        end
    end

    // Write enable is decoded from state so an asserted reset kills a pending spill at once.
    assign ram_wen = (state_reg == ST_WRITE);

    scratch_stack_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK   (CLK),
        .wen   (ram_wen),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (rdata)
    );

    assign op_if.op_ready = (state_reg == ST_IDLE);
    assign tos            = tos_reg;
    assign nos            = nos_reg;
    assign sp             = sp_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed bench for scratch_stack_ctrl (ADDR_W=2); expectations follow SCRATCH_STACK_GUARD_EN.
module tb_scratch_stack_ctrl;
    import scratch_stack_pkg::*;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic              CLK;
    logic              resetn;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] nos;
    logic [ADDR_W:0]   sp;
    logic              full;
    logic              empty;
    logic              err;

    int checks;
    int failures;

    scratch_stack_if #(.DATA_W(DATA_W)) op_if ();

    scratch_stack_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .op_if  (op_if),
        .tos    (tos),
        .nos    (nos),
        .sp     (sp),
        .full   (full),
        .empty  (empty),
        .err    (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits for idle, presents one command for one accept edge, waits for idle.
    task automatic issue(input string tag, input op_code_t code, input logic [31:0] data);
        int n;
        n = 0;
        while (op_if.op_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready_before"}, {31'd0, op_if.op_ready}, 32'd1);
        op_if.op_valid = 1'b1;
        op_if.op_code  = code;
        op_if.op_data  = data;
        @(negedge CLK);
        op_if.op_valid = 1'b0;
        op_if.op_code  = OP_NOP;
        n = 0;
        while (op_if.op_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready_after"}, {31'd0, op_if.op_ready}, 32'd1);
        $display("txn %s code=%0d data=0x%0h tos=0x%0h nos=0x%0h sp=%0d", tag, code, data, tos, nos, sp);
    endtask

    initial begin
        logic [31:0] push_vals [3];
        checks   = 0;
        failures = 0;
        push_vals[0] = 32'h11;
        push_vals[1] = 32'h22;
        push_vals[2] = 32'h33;

        resetn         = 1'b0;
        op_if.op_valid = 1'b0;
        op_if.op_code  = OP_NOP;
        op_if.op_data  = '0;

        // 1: reset state
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        check("rst_tos",   tos, 32'h0);
        check("rst_nos",   nos, 32'h0);
        check("rst_sp",    {29'd0, sp}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, op_if.op_ready}, 32'd1);

        // 2: back-to-back pushes with op_valid held; one accept every second edge
        op_if.op_valid = 1'b1;
        op_if.op_code  = OP_PUSH;
        for (int i = 0; i < 3; i++) begin
            op_if.op_data = push_vals[i];
            check("push_rdy_idle", {31'd0, op_if.op_ready}, 32'd1);
            @(negedge CLK);
            check("push_rdy_busy", {31'd0, op_if.op_ready}, 32'd0);
            check("push_tos", tos, push_vals[i]);
            @(negedge CLK);
            $display("txn push data=0x%0h tos=0x%0h nos=0x%0h sp=%0d", push_vals[i], tos, nos, sp);
        end
        op_if.op_valid = 1'b0;
        op_if.op_code  = OP_NOP;
        check("push3_tos", tos, 32'h33);
        check("push3_nos", nos, 32'h22);
        check("push3_sp",  {29'd0, sp}, 32'd3);

        // 3: three pops, each with op_ready low for exactly two cycles
        for (int i = 0; i < 3; i++) begin
            op_if.op_valid = 1'b1;
            op_if.op_code  = OP_POP;
            @(negedge CLK);
            op_if.op_valid = 1'b0;
            op_if.op_code  = OP_NOP;
            check("pop_busy1", {31'd0, op_if.op_ready}, 32'd0);
            @(negedge CLK);
            check("pop_busy2", {31'd0, op_if.op_ready}, 32'd0);
            @(negedge CLK);
            check("pop_idle", {31'd0, op_if.op_ready}, 32'd1);
            $display("txn pop tos=0x%0h nos=0x%0h sp=%0d", tos, nos, sp);
            if (i == 0) begin
                check("pop1_tos", tos, 32'h22);
                check("pop1_nos", nos, 32'h11);
                check("pop1_sp",  {29'd0, sp}, 32'd2);
            end else if (i == 1) begin
                check("pop2_tos", tos, 32'h11);
                check("pop2_nos", nos, 32'h0);
                check("pop2_sp",  {29'd0, sp}, 32'd1);
            end else begin
                check("pop3_tos",   tos, 32'h0);
                check("pop3_nos",   nos, 32'h0);
                check("pop3_sp",    {29'd0, sp}, 32'd0);
                check("pop3_empty", {31'd0, empty}, 32'd1);
            end
        end

        // 4: REPLACE then PUSH on the very next edge
        op_if.op_valid = 1'b1;
        op_if.op_code  = OP_REPLACE;
        op_if.op_data  = 32'hABCD;
        @(negedge CLK);
        check("repl_tos",   tos, 32'hABCD);
        check("repl_ready", {31'd0, op_if.op_ready}, 32'd1);
        check("repl_sp",    {29'd0, sp}, 32'd0);
        op_if.op_code = OP_PUSH;
        op_if.op_data = 32'h5;
        @(negedge CLK);
        op_if.op_valid = 1'b0;
        op_if.op_code  = OP_NOP;
        check("repl_push_tos", tos, 32'h5);
        check("repl_push_nos", nos, 32'hABCD);
        check("repl_push_sp",  {29'd0, sp}, 32'd1);
        $display("txn replace+push tos=0x%0h nos=0x%0h sp=%0d", tos, nos, sp);
        @(negedge CLK);

        // 5: fill to DEPTH and push once more
        resetn = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        for (int i = 1; i <= 4; i++) begin
            issue("fill_push", OP_PUSH, 32'(i));
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_sp",   {29'd0, sp}, 32'd4);
        issue("over_push", OP_PUSH, 32'd5);
`ifdef SCRATCH_STACK_GUARD_EN
        check("over_tos", tos, 32'd4);
        check("over_nos", nos, 32'd3);
        check("over_sp",  {29'd0, sp}, 32'd4);
        check("over_err", {31'd0, err}, 32'd1);
`else
        check("over_tos", tos, 32'd5);
        check("over_nos", nos, 32'd4);
        check("over_sp",  {29'd0, sp}, 32'd5);
        check("over_err", {31'd0, err}, 32'd0);
`endif

        // 6: reset asserted while a POP sits in RD_WAIT
        op_if.op_valid = 1'b1;
        op_if.op_code  = OP_POP;
        @(negedge CLK);
        op_if.op_valid = 1'b0;
        op_if.op_code  = OP_NOP;
        check("abort_busy", {31'd0, op_if.op_ready}, 32'd0);
        resetn = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        check("abort_tos",   tos, 32'h0);
        check("abort_nos",   nos, 32'h0);
        check("abort_sp",    {29'd0, sp}, 32'd0);
        check("abort_err",   {31'd0, err}, 32'd0);
        check("abort_ready", {31'd0, op_if.op_ready}, 32'd1);
        check("abort_empty", {31'd0, empty}, 32'd1);
        issue("post_abort_push", OP_PUSH, 32'h77);
        check("post_abort_tos", tos, 32'h77);
        check("post_abort_sp",  {29'd0, sp}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
